// File: rtl/frog_key_if.sv
// Button-side bundle for the frog-game input conditioner: raw keys and enable in,
// debounced levels plus tap/double-tap pulses out.
interface frog_key_if #(
  parameter int NUM_KEYS = 4
);
  logic                en;
  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] deb_n;
  logic [NUM_KEYS-1:0] tap;
  logic [NUM_KEYS-1:0] dtap;

  modport master (
    output en,
    output key_n,
    input  deb_n,
    input  tap,
    input  dtap
  );

  modport slave (
    input  en,
    input  key_n,
    output deb_n,
    output tap,
    output dtap
  );
endinterface

// File: rtl/frog_key_ctrl.sv
// Input conditioner for the frog-game core: per-key sync, debounce and
// single/double-tap classification, one lane instance per button.
module frog_key_lane #(
  parameter int DB_CYCLES = 16,
  parameter int DT_WINDOW = 64,
  parameter int CW        = 8
) (
  input  logic i_clk,
  input  logic i_rst,      // active-low, asynchronous
  input  logic i_en,
  input  logic i_key_n,
  output logic o_deb_n,
  output logic o_tap,
  output logic o_dtap
);

  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] WIN_LAST = CW'(DT_WINDOW - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRESS1 = 2'd1,
    S_WAIT   = 2'd2,
    S_PRESS2 = 2'd3
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_db_cnt;
  logic          r_deb;
  logic          r_deb_d;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_win;
  logic [CW-1:0] w_win_nxt;
  logic          w_press;
  logic          w_release;
  logic          w_tap;
  logic          w_dtap;
  logic          r_tap;
  logic          r_dtap;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Level flips only after DB_CYCLES consecutive mismatching cycles.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_db_cnt <= '0;
      r_deb    <= 1'b1;
    end else if (r_sync2 == r_deb) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_db_cnt <= '0;
      r_deb    <= r_sync2;
    end else begin
      r_db_cnt <= r_db_cnt + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_deb_d <= 1'b1;
    else        r_deb_d <= r_deb;
  end

  assign w_press   = r_deb_d & ~r_deb;
  assign w_release = ~r_deb_d & r_deb;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_win   <= '0;
      r_tap   <= 1'b0;
      r_dtap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_win   <= w_win_nxt;
      r_tap   <= w_tap;
      r_dtap  <= w_dtap;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    w_tap       = 1'b0;
    w_dtap      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_press) w_state_nxt = S_PRESS1;
      end
      S_PRESS1: begin
        if (w_release) begin
          w_state_nxt = S_WAIT;
          w_win_nxt   = '0;
        end
      end
      S_WAIT: begin
        // A press on the final window cycle still beats expiry.
        if (w_press && (r_win <= WIN_LAST)) begin
          w_state_nxt = S_PRESS2;
          w_dtap      = 1'b1;
        end else if (r_win == WIN_LAST) begin
          w_state_nxt = S_IDLE;
          w_tap       = 1'b1;
        end else begin
          w_win_nxt = r_win + CW'(1);
        end
      end
      S_PRESS2: begin
        if (w_release) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!i_en) begin
      w_state_nxt = S_IDLE;
      w_tap       = 1'b0;
      w_dtap      = 1'b0;
    end
  end

  assign o_deb_n = r_deb;
  assign o_tap   = r_tap;
  assign o_dtap  = r_dtap;

endmodule

module frog_key_ctrl #(
  parameter int DB_CYCLES = 16,
  parameter int DT_WINDOW = 64,
  parameter int CW        = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,   // active-low, asynchronous
  frog_key_if.slave  bus
);

  localparam int NUM_KEYS = 4;

  logic [NUM_KEYS-1:0] w_deb_n;
  logic [NUM_KEYS-1:0] w_tap;
  logic [NUM_KEYS-1:0] w_dtap;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
    frog_key_lane #(
      .DB_CYCLES (DB_CYCLES),
      .DT_WINDOW (DT_WINDOW),
      .CW        (CW)
    ) u_lane (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (bus.en),
      .i_key_n (bus.key_n[g]),
      .o_deb_n (w_deb_n[g]),
      .o_tap   (w_tap[g]),
      .o_dtap  (w_dtap[g])
    );
  end

  assign bus.deb_n = w_deb_n;
  assign bus.tap   = w_tap;
  assign bus.dtap  = w_dtap;

endmodule
